ysyx_25040129_lsu: RTL and testbench
====================================

# ysyx_25040129_lsu

Memory-access stage of the ysyx_25040129 pipeline, directly downstream of the execute stage. It accepts one instruction per valid/ready handshake from EXU and issues at most one load or store on a single-outstanding memory request/response bus. Loads are sign- or zero-extended, and stores get byte-lane replication and strobes. Writeback fields go to WBU through a registered valid/ready output, and a forwarding tap is provided for the hazard unit.

## Interface
- CTRL_W, default 16: width of the opaque sideband bundle passed EXU→WBU untouched (rd, reg_write, csr_write, csr_write_addr, ecall, mret, ebreak, fence_i).
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  **asynchronous, active-high reset.**
- is_req_valid_from_exu  in  1  EXU holds a valid instruction.
- is_req_ready_to_exu  out  1  LSU can accept this cycle.
- result_in_lsu  in  32  EXU result: the effective address for memory ops, the ALU value otherwise.
- lsu_write_data_in_lsu  in  32  store source data.
- lsu_read_in_lsu  in  3  load kind.
- lsu_write_in_lsu  in  2  store kind.
- rd_in_lsu  in  5  destination register (also contained in ctrl).
- reg_write_in_lsu  in  1  writes rd.
- ctrl_in_lsu  in  CTRL_W  sideband bundle.
- mem_req_valid / mem_req_ready  out / in  1  request handshake.
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_req_wen  out  1  1 = store.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_req_wstrb  out  4  byte strobes; 0 for loads.
- mem_rsp_valid  in  1  response (load data or store ack); always accepted.
- mem_rsp_rdata  in  32  load word.
- mem_rsp_err  in  1  bus error.
- is_req_valid_to_wbu / is_req_ready_from_wbu  out / in  1  output handshake.
- result_out_lsu  out  32  final writeback value.
- ctrl_out_lsu  out  CTRL_W  registered sideband.
- lsu_fault_out  out  1  misaligned access or bus error.
- is_data_forward_valid_from_lsu  out  1  output register holds valid reg_write data.
- forward_rd_out  out  5  rd of the held output.

## Operation
- Encodings: read NONE=000, LB=001, LH=010, LW=011, LBU=100, LHU=101. Write NONE=00, SB=01, SH=10, SW=11.
- FSM states: IDLE, REQ, WAIT, OUT.
- IDLE:
  - Ready = 1 when the output register is empty or is being consumed this cycle.
  - On accept, latch all inputs.
  - Non-memory op → OUT, with result = result_in.
  - Memory op, misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) → OUT, with fault = 1, result = address, and no bus access.
  - Otherwise → REQ.
- REQ: mem_req_valid = 1 with addr, wen, wdata, and wstrb held stable until mem_req_ready. On handshake → WAIT. If mem_rsp_valid arrives in the same cycle as the handshake, go directly to OUT.
- WAIT: on mem_rsp_valid, capture and extend the data → OUT. fault = mem_rsp_err.
- OUT: is_req_valid_to_wbu = 1, fields held stable. On is_req_ready_from_wbu go to IDLE; a new EXU accept in that same cycle is allowed (back-to-back).
- Load extension: lane = addr[1:0].
  - LB/LBU: rdata[8*lane +: 8], sign-extended / zero-extended.
  - LH/LHU: rdata[8*lane +: 16], sign-extended / zero-extended.
  - LW: the full word.
- Store formatting:
  - SB: wdata = {4{d[7:0]}}, wstrb = 0001<<lane.
  - SH: wdata = {2{d[15:0]}}, wstrb = 0011<<lane.
  - SW: wdata = d, wstrb = 1111.
- Stores: result_out = latched result_in; the reg_write bit in ctrl is passed unchanged.
- Forwarding: forward_valid = (state==OUT) & reg_write & ~fault.
- Only one transaction is ever outstanding. EXU stalls (ready = 0) in REQ, WAIT, and in OUT while WBU is not ready.

## Timing
- Reset values:
  - state = IDLE.
  - is_req_ready_to_exu = 1.
  - mem_req_valid = 0; mem_req_addr, wdata, wstrb = 0; mem_req_wen = 0.
  - is_req_valid_to_wbu = 0, result_out = 0, ctrl_out = 0, fault = 0, forward_valid = 0, forward_rd = 0.
- Non-memory op: accepted in cycle T → valid_to_wbu in T+1. Throughput is 1/cycle when WBU is always ready.
- Memory op, zero-wait bus (ready at T+1, rsp at T+2): output valid at T+3.
- Reset asserted mid-transaction: immediately returns to IDLE and drops mem_req_valid. Any later mem_rsp_valid seen in IDLE is ignored.
- A mem_rsp_valid seen outside WAIT (or the REQ handshake cycle) is ignored.

## Structure
- The read/write encodings, state encoding, and the WORD constant go in the shared ysyx_25040129 defines file alongside the existing ALU opcodes; no literals in the module.
- One natural sub-module, ysyx_25040129_lsu_align, is purely combinational: it produces the store wdata/wstrb, the load extract/extend, and the misalignment flag.

## Test plan
- ADD result 0x1234, no memory op, WBU ready → result_out 0x1234 one cycle after accept; no mem_req_valid ever.
- SB data 0xAABBCCDD at address 0x80000003 → mem_req_addr 0x80000000, wdata 0xDDDDDDDD, wstrb 1000, wen = 1.
- LB at 0x80000001, rdata 0x0000F000 → result 0xFFFFFFF0; the same access as LBU → 0x000000F0.
- LW at 0x80000002 → fault = 1, result 0x80000002, no bus request, output valid at T+1.
- Load with mem_req_ready low for 3 cycles and WBU stalled 2 cycles → request fields stable throughout, EXU ready = 0 throughout, exactly one transfer to WBU.
- rst asserted while in WAIT, then a stale rsp arrives → outputs at reset values, rsp ignored, next op processed normally.

Source files
------------

// File: rtl/ysyx_25040129_lsu_pkg.sv
// rtl/ysyx_25040129_lsu_pkg.sv - shared LSU encodings, FSM states and width constants
package ysyx_25040129_lsu_pkg;

  localparam int WORD  = 32;
  localparam int LANES = WORD / 8;

  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LH   = 3'b010,
    RD_LW   = 3'b011,
    RD_LBU  = 3'b100,
    RD_LHU  = 3'b101
  } rd_kind_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_SB   = 2'b01,
    WR_SH   = 2'b10,
    WR_SW   = 2'b11
  } wr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } state_e;

  localparam logic [LANES-1:0] STRB_NONE = 4'b0000;
  localparam logic [LANES-1:0] STRB_BYTE = 4'b0001;
  localparam logic [LANES-1:0] STRB_HALF = 4'b0011;
  localparam logic [LANES-1:0] STRB_WORD = 4'b1111;
  localparam logic [WORD-1:0]  LANE_MASK = 32'h0000_0003;

endpackage

// File: rtl/ysyx_25040129_lsu_if.sv
// rtl/ysyx_25040129_lsu_if.sv - EXU, memory bus and WBU signals seen by the LSU
interface ysyx_25040129_lsu_if #(
  parameter int CTRL_W = 16
) ();
  import ysyx_25040129_lsu_pkg::*;

  logic              is_req_valid_from_exu;
  logic              is_req_ready_to_exu;
  logic [WORD-1:0]   result_in_lsu;
  logic [WORD-1:0]   lsu_write_data_in_lsu;
  logic [2:0]        lsu_read_in_lsu;
  logic [1:0]        lsu_write_in_lsu;
  logic [4:0]        rd_in_lsu;
  logic              reg_write_in_lsu;
  logic [CTRL_W-1:0] ctrl_in_lsu;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [WORD-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [WORD-1:0]   mem_req_wdata;
  logic [LANES-1:0]  mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [WORD-1:0]   mem_rsp_rdata;
  logic              mem_rsp_err;

  logic              is_req_valid_to_wbu;
  logic              is_req_ready_from_wbu;
  logic [WORD-1:0]   result_out_lsu;
  logic [CTRL_W-1:0] ctrl_out_lsu;
  logic              lsu_fault_out;
  logic              is_data_forward_valid_from_lsu;
  logic [4:0]        forward_rd_out;

  modport slave (
    input  is_req_valid_from_exu, result_in_lsu, lsu_write_data_in_lsu, lsu_read_in_lsu,
           lsu_write_in_lsu, rd_in_lsu, reg_write_in_lsu, ctrl_in_lsu,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err, is_req_ready_from_wbu,
    output is_req_ready_to_exu, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, is_req_valid_to_wbu, result_out_lsu, ctrl_out_lsu, lsu_fault_out,
           is_data_forward_valid_from_lsu, forward_rd_out
  );

  modport master (
    output is_req_valid_from_exu, result_in_lsu, lsu_write_data_in_lsu, lsu_read_in_lsu,
           lsu_write_in_lsu, rd_in_lsu, reg_write_in_lsu, ctrl_in_lsu,
           mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err, is_req_ready_from_wbu,
    input  is_req_ready_to_exu, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata,
           mem_req_wstrb, is_req_valid_to_wbu, result_out_lsu, ctrl_out_lsu, lsu_fault_out,
           is_data_forward_valid_from_lsu, forward_rd_out
  );

endinterface

// File: rtl/ysyx_25040129_lsu_align.sv
// rtl/ysyx_25040129_lsu_align.sv - store lane replication/strobes, load extract/extend, misalignment
module ysyx_25040129_lsu_align
  import ysyx_25040129_lsu_pkg::*;
(
  input  logic [1:0]       lane_i,
  input  rd_kind_e         rd_kind_i,
  input  wr_kind_e         wr_kind_i,
  input  logic [WORD-1:0]  store_data_i,
  input  logic [WORD-1:0]  load_word_i,
  output logic [WORD-1:0]  wdata_o,
  output logic [LANES-1:0] wstrb_o,
  output logic [WORD-1:0]  load_data_o,
  output logic             misaligned_o
);

  logic [15:0] lane_bits;

  assign lane_bits = 16'(load_word_i >> (8 * int'(lane_i)));

  always_comb begin
    wdata_o = '0;
    wstrb_o = STRB_NONE;
    case (wr_kind_i)
      WR_SB: begin
        wdata_o = {LANES{store_data_i[7:0]}};
        wstrb_o = STRB_BYTE << lane_i;
      end
      WR_SH: begin
        wdata_o = {2{store_data_i[15:0]}};
        wstrb_o = STRB_HALF << lane_i;
      end
      WR_SW: begin
        wdata_o = store_data_i;
        wstrb_o = STRB_WORD;
      end
      default: ;
    endcase
  end

  always_comb begin
    load_data_o = load_word_i;
    case (rd_kind_i)
      RD_LB:   load_data_o = {{24{lane_bits[7]}}, lane_bits[7:0]};
      RD_LBU:  load_data_o = {24'd0, lane_bits[7:0]};
      RD_LH:   load_data_o = {{16{lane_bits[15]}}, lane_bits};
      RD_LHU:  load_data_o = {16'd0, lane_bits};
      default: ;
    endcase
  end

  always_comb begin
    misaligned_o = 1'b0;
    case (rd_kind_i)
      RD_LH, RD_LHU: misaligned_o = lane_i[0];
      RD_LW:         misaligned_o = |lane_i;
      default: ;
    endcase
    case (wr_kind_i)
      WR_SH:   misaligned_o = misaligned_o | lane_i[0];
      WR_SW:   misaligned_o = misaligned_o | (|lane_i);
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040129_lsu.sv
// rtl/ysyx_25040129_lsu.sv - memory-access stage: EXU handshake, single-outstanding bus op, registered WBU output
module ysyx_25040129_lsu
  import ysyx_25040129_lsu_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input logic                clk,
  input logic                rst,
  ysyx_25040129_lsu_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD-1:0]   addr_q, addr_d, sdata_q, sdata_d, result_q, result_d;
  rd_kind_e          rkind_q, rkind_d;
  wr_kind_e          wkind_q, wkind_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d, fault_q, fault_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic              busy_bus, req_active, exu_ready, accept, in_is_mem, misaligned;
  rd_kind_e          rkind_in, al_rkind;
  wr_kind_e          wkind_in, al_wkind;
  logic [1:0]        al_lane;
  logic [WORD-1:0]   al_wdata, al_load, cap_result;
  logic [LANES-1:0]  al_wstrb;

  assign rkind_in   = rd_kind_e'(bus.lsu_read_in_lsu);
  assign wkind_in   = wr_kind_e'(bus.lsu_write_in_lsu);
  assign in_is_mem  = (rkind_in != RD_NONE) || (wkind_in != WR_NONE);
  assign busy_bus   = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign req_active = (state_q == ST_REQ);

  // While a bus op is in flight the aligner serves the latched op; otherwise it screens the incoming one.
  assign al_lane  = busy_bus ? addr_q[1:0] : bus.result_in_lsu[1:0];
  assign al_rkind = busy_bus ? rkind_q : rkind_in;
  assign al_wkind = busy_bus ? wkind_q : wkind_in;

  ysyx_25040129_lsu_align u_align (
    .lane_i       (al_lane),
    .rd_kind_i    (al_rkind),
    .wr_kind_i    (al_wkind),
    .store_data_i (sdata_q),
    .load_word_i  (bus.mem_rsp_rdata),
    .wdata_o      (al_wdata),
    .wstrb_o      (al_wstrb),
    .load_data_o  (al_load),
    .misaligned_o (misaligned)
  );

  assign cap_result = (wkind_q != WR_NONE) ? addr_q : al_load;
  assign exu_ready  = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.is_req_ready_from_wbu);
  assign accept     = exu_ready && bus.is_req_valid_from_exu;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    result_d = result_q;
    rkind_d  = rkind_q;
    wkind_d  = wkind_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    fault_d  = fault_q;
    ctrl_d   = ctrl_q;
    case (state_q)
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          if (bus.mem_rsp_valid) begin
            state_d  = ST_OUT;
            result_d = cap_result;
            fault_d  = bus.mem_rsp_err;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d  = ST_OUT;
          result_d = cap_result;
          fault_d  = bus.mem_rsp_err;
        end
      end
      ST_OUT: begin
        if (bus.is_req_ready_from_wbu) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      addr_d  = bus.result_in_lsu;
      sdata_d = bus.lsu_write_data_in_lsu;
      rkind_d = rkind_in;
      wkind_d = wkind_in;
      rd_d    = bus.rd_in_lsu;
      rw_d    = bus.reg_write_in_lsu;
      ctrl_d  = bus.ctrl_in_lsu;
      fault_d = 1'b0;
      if (!in_is_mem || misaligned) begin
        state_d  = ST_OUT;
        result_d = bus.result_in_lsu;
        fault_d  = in_is_mem;
      end else begin
        state_d = ST_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      sdata_q  <= '0;
      result_q <= '0;
      rkind_q  <= RD_NONE;
      wkind_q  <= WR_NONE;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      fault_q  <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      result_q <= result_d;
      rkind_q  <= rkind_d;
      wkind_q  <= wkind_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      fault_q  <= fault_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign bus.is_req_ready_to_exu            = exu_ready;
  assign bus.mem_req_valid                  = req_active;
  assign bus.mem_req_addr                   = req_active ? (addr_q & ~LANE_MASK) : '0;
  assign bus.mem_req_wen                    = req_active && (wkind_q != WR_NONE);
  assign bus.mem_req_wdata                  = req_active ? al_wdata : '0;
  assign bus.mem_req_wstrb                  = req_active ? al_wstrb : STRB_NONE;
  assign bus.is_req_valid_to_wbu            = (state_q == ST_OUT);
  assign bus.result_out_lsu                 = result_q;
  assign bus.ctrl_out_lsu                   = ctrl_q;
  assign bus.lsu_fault_out                  = fault_q;
  assign bus.is_data_forward_valid_from_lsu = (state_q == ST_OUT) && rw_q && !fault_q;
  assign bus.forward_rd_out                 = rd_q;

endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// tb/tb_ysyx_25040129_lsu.sv - vector table plus stall/reset sequences, scoreboarded memory and WBU models
module tb_ysyx_25040129_lsu;
  import ysyx_25040129_lsu_pkg::*;

  localparam int CTRL_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25040129_lsu_if #(.CTRL_W(CTRL_W)) lif ();
  ysyx_25040129_lsu #(.CTRL_W(CTRL_W)) dut (.clk(clk), .rst(rst), .bus(lif.slave));

  typedef struct {
    logic [2:0]  rk;
    logic [1:0]  wk;
    logic [31:0] addr, sdata, rdata;
    logic        err;
    logic [31:0] exp_res;
    logic        exp_fault, exp_bus;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0]       res;
    logic              fault;
    logic [CTRL_W-1:0] ctrl;
    logic              fwd;
    logic [4:0]        rd;
    int                acc_cyc;
    int                lat;
  } out_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        wen;
    logic [31:0] rdata;
    logic        err;
  } req_t;

  out_t sb_q[$];
  req_t req_q[$];
  vec_t tbl[12];
  int errors = 0, checks = 0, cyc = 0;
  int hs_count = 0, exp_hs = 0, wbu_count = 0, last_acc = 0;
  int mem_stall = 0, wbu_stall = 0;
  bit mem_drop = 0, stale_rsp = 0, hs_seen = 0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: ready/stall decided after each edge, handshake observed at negedge, response one cycle later.
  initial begin
    req_t r;
    lif.mem_req_ready = 1'b0;
    lif.mem_rsp_valid = 1'b0;
    lif.mem_rsp_rdata = '0;
    lif.mem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk); #1;
      lif.mem_rsp_valid = hs_seen || stale_rsp;
      lif.mem_rsp_rdata = rsp_data;
      lif.mem_rsp_err   = rsp_err;
      hs_seen   = 0;
      stale_rsp = 0;
      if (lif.mem_req_valid && mem_stall > 0) begin
        lif.mem_req_ready = 1'b0;
        mem_stall--;
      end else begin
        lif.mem_req_ready = lif.mem_req_valid;
      end
      @(negedge clk);
      if (lif.mem_req_valid && lif.mem_req_ready) begin
        hs_count++;
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", lif.mem_req_addr);
        end else begin
          r = req_q.pop_front();
          checks--;
          check("mem_req_addr", lif.mem_req_addr, r.addr);
          check("mem_req_wdata", lif.mem_req_wdata, r.wdata);
          check("mem_req_wstrb", 32'(lif.mem_req_wstrb), 32'(r.wstrb));
          check("mem_req_wen", 32'(lif.mem_req_wen), 32'(r.wen));
          rsp_data = r.rdata;
          rsp_err  = r.err;
          hs_seen  = !mem_drop;
        end
      end
    end
  end

  // WBU model: pops the scoreboard on each output handshake.
  initial begin
    out_t o;
    lif.is_req_ready_from_wbu = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (lif.is_req_valid_to_wbu && wbu_stall > 0) begin
        lif.is_req_ready_from_wbu = 1'b0;
        wbu_stall--;
      end else begin
        lif.is_req_ready_from_wbu = 1'b1;
      end
      @(negedge clk);
      if (lif.is_req_valid_to_wbu && lif.is_req_ready_from_wbu && !rst) begin
        wbu_count++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wbu_out: got result 0x%08h, expected no output", lif.result_out_lsu);
        end else begin
          o = sb_q.pop_front();
          check("result_out", lif.result_out_lsu, o.res);
          check("fault_out", 32'(lif.lsu_fault_out), 32'(o.fault));
          check("ctrl_out", 32'(lif.ctrl_out_lsu), 32'(o.ctrl));
          check("fwd_valid", 32'(lif.is_data_forward_valid_from_lsu), 32'(o.fwd));
          check("fwd_rd", 32'(lif.forward_rd_out), 32'(o.rd));
          if (o.lat > 0) check("latency", 32'(cyc - o.acc_cyc), 32'(o.lat));
        end
      end
    end
  end

  task automatic drive(input vec_t v, input int idx);
    out_t o;
    req_t r;
    int   waited = 0;
    @(posedge clk); #1;
    lif.is_req_valid_from_exu = 1'b1;
    lif.result_in_lsu         = v.addr;
    lif.lsu_write_data_in_lsu = v.sdata;
    lif.lsu_read_in_lsu       = v.rk;
    lif.lsu_write_in_lsu      = v.wk;
    lif.rd_in_lsu             = 5'(idx + 1);
    lif.reg_write_in_lsu      = (v.wk == 2'b00);
    lif.ctrl_in_lsu           = 16'hA500 | 16'(idx);
    @(negedge clk);
    while (!lif.is_req_ready_to_exu && waited < 100) begin
      waited++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    if (!lif.is_req_ready_to_exu) begin
      checks++;
      errors++;
      $display("FAIL exu_accept_timeout: got ready 0 for op %0d, expected ready within 100 cycles", idx);
    end else begin
      o.res = v.exp_res; o.fault = v.exp_fault; o.ctrl = 16'hA500 | 16'(idx);
      o.fwd = (v.wk == 2'b00) && !v.exp_fault; o.rd = 5'(idx + 1);
      o.acc_cyc = cyc; o.lat = v.exp_lat;
      last_acc = cyc;
      sb_q.push_back(o);
      if (v.exp_bus) begin
        r.addr = v.exp_addr; r.wdata = v.exp_wdata; r.wstrb = v.exp_wstrb;
        r.wen = (v.wk != 2'b00); r.rdata = v.rdata; r.err = v.err;
        req_q.push_back(r);
        exp_hs++;
      end
    end
  endtask

  task automatic idle_exu();
    @(posedge clk); #1;
    lif.is_req_valid_from_exu = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || req_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(sb_q.size() + req_q.size()), 32'd0);
    sb_q.delete();
    req_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready_to_exu"}, 32'(lif.is_req_ready_to_exu), 32'd1);
    check({tag, "_mem_req_valid"}, 32'(lif.mem_req_valid), 32'd0);
    check({tag, "_mem_req_addr"}, lif.mem_req_addr, 32'd0);
    check({tag, "_mem_req_wdata"}, lif.mem_req_wdata, 32'd0);
    check({tag, "_mem_req_wstrb"}, 32'(lif.mem_req_wstrb), 32'd0);
    check({tag, "_mem_req_wen"}, 32'(lif.mem_req_wen), 32'd0);
    check({tag, "_valid_to_wbu"}, 32'(lif.is_req_valid_to_wbu), 32'd0);
    check({tag, "_result_out"}, lif.result_out_lsu, 32'd0);
    check({tag, "_ctrl_out"}, 32'(lif.ctrl_out_lsu), 32'd0);
    check({tag, "_fault_out"}, 32'(lif.lsu_fault_out), 32'd0);
    check({tag, "_fwd_valid"}, 32'(lif.is_data_forward_valid_from_lsu), 32'd0);
    check({tag, "_fwd_rd"}, 32'(lif.forward_rd_out), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   a0, n, req_cycles, wbu_wait_cycles, base_wbu, base_hs;
    bit   unstable, exu_leak, stale_out;
    logic [31:0] f_addr, f_wdata;

    rst = 1'b1;
    lif.is_req_valid_from_exu = 1'b0;
    lif.result_in_lsu = '0; lif.lsu_write_data_in_lsu = '0;
    lif.lsu_read_in_lsu = '0; lif.lsu_write_in_lsu = '0;
    lif.rd_in_lsu = '0; lif.reg_write_in_lsu = 1'b0; lif.ctrl_in_lsu = '0;
    repeat (2) @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1;
    rst = 1'b0;

    //         rk     wk     addr          sdata         rdata         err  exp_res       flt  bus  exp_addr      exp_wdata     strb     lat
    tbl[0]  = '{3'd0, 2'd0, 32'h0000_1234, 32'h0,        32'h0,        1'b0, 32'h0000_1234, 1'b0, 1'b0, 32'h0,        32'h0,        4'b0000, 1};
    tbl[1]  = '{3'd0, 2'd1, 32'h8000_0003, 32'hAABB_CCDD, 32'h0,       1'b0, 32'h8000_0003, 1'b0, 1'b1, 32'h8000_0000, 32'hDDDD_DDDD, 4'b1000, 3};
    tbl[2]  = '{3'd1, 2'd0, 32'h8000_0001, 32'h0,        32'h0000_F000, 1'b0, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4'b0000, 3};
    tbl[3]  = '{3'd4, 2'd0, 32'h8000_0001, 32'h0,        32'h0000_F000, 1'b0, 32'h0000_00F0, 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4'b0000, 3};
    tbl[4]  = '{3'd3, 2'd0, 32'h8000_0002, 32'h0,        32'h0,        1'b0, 32'h8000_0002, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 1};
    tbl[5]  = '{3'd2, 2'd0, 32'h8000_0002, 32'h0,        32'h8001_0000, 1'b0, 32'hFFFF_8001, 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4'b0000, 3};
    tbl[6]  = '{3'd5, 2'd0, 32'h8000_0002, 32'h0,        32'h8001_0000, 1'b0, 32'h0000_8001, 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4'b0000, 3};
    tbl[7]  = '{3'd0, 2'd2, 32'h8000_0002, 32'h1234_5678, 32'h0,       1'b0, 32'h8000_0002, 1'b0, 1'b1, 32'h8000_0000, 32'h5678_5678, 4'b1100, 3};
    tbl[8]  = '{3'd0, 2'd3, 32'h8000_0000, 32'hCAFE_BABE, 32'h0,       1'b0, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_BABE, 4'b1111, 3};
    tbl[9]  = '{3'd3, 2'd0, 32'h8000_0004, 32'h0,        32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h8000_0004, 32'h0,        4'b0000, 3};
    tbl[10] = '{3'd0, 2'd2, 32'h8000_0001, 32'h1111_2222, 32'h0,       1'b0, 32'h8000_0001, 1'b1, 1'b0, 32'h0,        32'h0,        4'b0000, 1};
    tbl[11] = '{3'd1, 2'd0, 32'h8000_0003, 32'h0,        32'h7F00_0000, 1'b0, 32'h0000_007F, 1'b0, 1'b1, 32'h8000_0000, 32'h0,        4'b0000, 3};

    for (int i = 0; i < 12; i++) drive(tbl[i], i);
    idle_exu();
    drain("table");
    check("table_bus_transfers", 32'(hs_count), 32'(exp_hs));

    // Back-to-back ALU ops must be accepted on consecutive cycles.
    for (int k = 0; k < 4; k++) begin
      v = tbl[0];
      v.addr = 32'h0000_0100 + 32'(k);
      v.exp_res = v.addr;
      drive(v, 12 + k);
      if (k == 0) a0 = last_acc;
    end
    idle_exu();
    check("b2b_accept_span", 32'(last_acc - a0), 32'd3);
    drain("b2b");

    // Stalled bus and stalled WBU around one load.
    mem_stall = 3; wbu_stall = 2;
    base_wbu = wbu_count;
    v = '{3'd3, 2'd0, 32'h8000_0010, 32'h0, 32'h1122_3344, 1'b0, 32'h1122_3344, 1'b0, 1'b1,
          32'h8000_0010, 32'h0, 4'b0000, 0};
    drive(v, 20);
    idle_exu();
    req_cycles = 0; wbu_wait_cycles = 0; unstable = 0; exu_leak = 0;
    f_addr = '0; f_wdata = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (lif.mem_req_valid) begin
        if (req_cycles == 0) begin
          f_addr = lif.mem_req_addr; f_wdata = lif.mem_req_wdata;
        end else if (lif.mem_req_addr !== f_addr || lif.mem_req_wdata !== f_wdata ||
                     lif.mem_req_wstrb !== 4'b0000 || lif.mem_req_wen !== 1'b0) begin
          unstable = 1;
        end
        req_cycles++;
        if (lif.is_req_ready_to_exu) exu_leak = 1;
      end
      if (lif.is_req_valid_to_wbu && !lif.is_req_ready_from_wbu) begin
        wbu_wait_cycles++;
        if (lif.is_req_ready_to_exu) exu_leak = 1;
      end
    end
    check("stall_req_cycles", 32'(req_cycles), 32'd4);
    check("stall_req_fields_stable", 32'(unstable), 32'd0);
    check("stall_wbu_wait_cycles", 32'(wbu_wait_cycles), 32'd2);
    check("stall_exu_ready_low", 32'(exu_leak), 32'd0);
    check("stall_single_transfer", 32'(wbu_count - base_wbu), 32'd1);
    drain("stall");

    // Reset while waiting for the response, then a stale response.
    mem_drop = 1;
    base_hs = hs_count;
    v.addr = 32'h8000_0020; v.exp_addr = 32'h8000_0020; v.rdata = 32'hDEAD_BEEF; v.exp_res = 32'hDEAD_BEEF;
    drive(v, 21);
    idle_exu();
    n = 0;
    while (hs_count == base_hs && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_seq_handshake", 32'(hs_count - base_hs), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_reset_state("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_drop = 0;
    @(negedge clk);
    rsp_data = 32'h0BAD_0BAD; rsp_err = 1'b1;
    stale_rsp = 1;
    stale_out = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (lif.is_req_valid_to_wbu || lif.mem_req_valid || !lif.is_req_ready_to_exu) stale_out = 1;
    end
    check("stale_rsp_ignored", 32'(stale_out), 32'd0);
    drive(tbl[0], 22);
    idle_exu();
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion before 500000");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
